// File: rtl/matmul_systolic_engine.sv
// Output-stationary systolic matrix multiplier: C = A*B or C += A*B on a MAX_DIM x MAX_DIM PE grid.
// Optional build macro MATMUL_SATURATE_EN: clamp overflowing accumulators instead of wrapping.
module matmul_systolic_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH,
    localparam int MAX_DIM   = BUS_WIDTH/DATA_WIDTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    start_i,
    input  logic                                    mode_i,
    input  logic [2:0]                              n_dim_i,
    input  logic [2:0]                              k_dim_i,
    input  logic [2:0]                              m_dim_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   a_matrix_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   b_matrix_i,
    output logic [MAX_DIM*MAX_DIM*ACC_WIDTH-1:0]    c_matrix_o,
    output logic [MAX_DIM*MAX_DIM-1:0]              flags_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    error_o
);
    localparam int PW = 2*DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                         r_state;
    logic [5:0]                     r_cnt;
    logic [2:0]                     r_n, r_k, r_m;
    logic signed [DATA_WIDTH-1:0]   r_a   [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   r_b   [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   r_pa  [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   r_pb  [MAX_DIM][MAX_DIM];
    logic signed [ACC_WIDTH-1:0]    r_acc [MAX_DIM][MAX_DIM];
    logic                           r_flag[MAX_DIM][MAX_DIM];
`ifdef MATMUL_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic                           r_sat [MAX_DIM][MAX_DIM];
`endif

    logic signed [DATA_WIDTH-1:0]   w_a_feed[MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   w_b_feed[MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   w_a_in [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0]   w_b_in [MAX_DIM][MAX_DIM];
    logic signed [PW-1:0]           w_prod [MAX_DIM][MAX_DIM];
    logic signed [ACC_WIDTH-1:0]    w_ext  [MAX_DIM][MAX_DIM];
    logic signed [ACC_WIDTH-1:0]    w_sum  [MAX_DIM][MAX_DIM];
    logic                           w_ovf  [MAX_DIM][MAX_DIM];
    logic                           w_legal;
    logic                           w_accept;
    logic [5:0]                     w_feed_last;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d != 3'd0) && (int'(d) <= MAX_DIM);
    endfunction

    assign w_legal     = dim_ok(n_dim_i) && dim_ok(k_dim_i) && dim_ok(m_dim_i);
    assign w_accept    = (r_state == S_IDLE) && start_i && w_legal;
    assign w_feed_last = 6'(r_n) + 6'(r_k) + 6'(r_m) - 6'd3;

    // Skewed edge feed: row r sees A[r][t-r], column c sees B[t-c][c], zero outside the operands.
    always_comb begin
        for (int i = 0; i < MAX_DIM; i++) begin
            w_a_feed[i] = '0;
            w_b_feed[i] = '0;
            for (int kk = 0; kk < MAX_DIM; kk++) begin
                if ((i < int'(r_n)) && (kk < int'(r_k)) && (int'(r_cnt) == i + kk))
                    w_a_feed[i] = r_a[i][kk];
                if ((i < int'(r_m)) && (kk < int'(r_k)) && (int'(r_cnt) == i + kk))
                    w_b_feed[i] = r_b[kk][i];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                w_a_in[r][c] = (c == 0) ? w_a_feed[r] : r_pa[r][(c == 0) ? 0 : c-1];
                w_b_in[r][c] = (r == 0) ? w_b_feed[c] : r_pb[(r == 0) ? 0 : r-1][c];
                w_prod[r][c] = PW'(w_a_in[r][c]) * PW'(w_b_in[r][c]);
                w_ext[r][c]  = ACC_WIDTH'(w_prod[r][c]);
                w_sum[r][c]  = r_acc[r][c] + w_ext[r][c];
                w_ovf[r][c]  = (r_acc[r][c][ACC_WIDTH-1] == w_ext[r][c][ACC_WIDTH-1]) &&
                               (w_sum[r][c][ACC_WIDTH-1] != r_acc[r][c][ACC_WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    r_pa[r][c]   <= '0;
                    r_pb[r][c]   <= '0;
                    r_acc[r][c]  <= '0;
                    r_flag[r][c] <= 1'b0;
`ifdef MATMUL_SATURATE_EN
                    r_sat[r][c]  <= 1'b0;
`endif
                end
            end
        end else if (w_accept) begin
            // Accumulate mode seeds each PE from the held result and its sticky flag.
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    r_pa[r][c]   <= '0;
                    r_pb[r][c]   <= '0;
                    r_acc[r][c]  <= mode_i ? c_matrix_o[(r*MAX_DIM+c)*ACC_WIDTH +: ACC_WIDTH] : '0;
                    r_flag[r][c] <= mode_i & flags_o[r*MAX_DIM+c];
`ifdef MATMUL_SATURATE_EN
                    r_sat[r][c]  <= 1'b0;
`endif
                end
            end
        end else if (r_state == S_FEED) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    r_pa[r][c]   <= w_a_in[r][c];
                    r_pb[r][c]   <= w_b_in[r][c];
                    r_flag[r][c] <= r_flag[r][c] | w_ovf[r][c];
`ifdef MATMUL_SATURATE_EN
                    if (!r_sat[r][c]) begin
                        r_sat[r][c] <= w_ovf[r][c];
                        if (w_ovf[r][c])
                            r_acc[r][c] <= r_acc[r][c][ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
                        else
                            r_acc[r][c] <= w_sum[r][c];
                    end
`else
                    r_acc[r][c]  <= w_sum[r][c];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_m        <= '0;
            c_matrix_o <= '0;
            flags_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    r_a[r][c] <= '0;
                    r_b[r][c] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n    <= n_dim_i;
                        r_k    <= k_dim_i;
                        r_m    <= m_dim_i;
                        busy_o <= 1'b1;
                        r_cnt  <= '0;
                        for (int r = 0; r < MAX_DIM; r++) begin
                            for (int c = 0; c < MAX_DIM; c++) begin
                                r_a[r][c] <= a_matrix_i[(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
                                r_b[r][c] <= b_matrix_i[(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                        if (w_legal) begin
                            error_o <= 1'b0;
                            r_state <= S_FEED;
                        end else begin
                            error_o <= 1'b1;
                            done_o  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FEED: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == w_feed_last)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    done_o  <= 1'b1;
                    r_state <= S_DONE;
                    for (int r = 0; r < MAX_DIM; r++) begin
                        for (int c = 0; c < MAX_DIM; c++) begin
                            c_matrix_o[(r*MAX_DIM+c)*ACC_WIDTH +: ACC_WIDTH] <=
                                ((r < int'(r_n)) && (c < int'(r_m))) ? r_acc[r][c] : '0;
                            flags_o[r*MAX_DIM+c] <=
                                (r < int'(r_n)) && (c < int'(r_m)) && r_flag[r][c];
                        end
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_systolic_engine.sv
// Directed bench for matmul_systolic_engine at DATA_WIDTH=8, BUS_WIDTH=32 (4x4 array).
// Define MATMUL_SATURATE_EN here as for the RTL to select the clamped overflow expectations.
module tb_matmul_systolic_engine;
    logic           clk_i;
    logic           rst_ni;
    logic           start_i;
    logic           mode_i;
    logic [2:0]     n_dim_i, k_dim_i, m_dim_i;
    logic [127:0]   a_matrix_i, b_matrix_i;
    logic [255:0]   c_matrix_o;
    logic [15:0]    flags_o;
    logic           busy_o, done_o, error_o;

    int             n_cmp = 0;
    int             n_err = 0;
    logic [15:0]    exp_q[$];
    int             exp_c[16];
    int             lat, pulses;
    logic           busy1;
    logic [127:0]   a_id, b_2x2, a_ones, a_nk, b_km, a_nines;

    matmul_systolic_engine dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
        .a_matrix_i(a_matrix_i), .b_matrix_i(b_matrix_i),
        .c_matrix_o(c_matrix_o), .flags_o(flags_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] put(input logic [127:0] m, input int r, input int c, input int v);
        logic [31:0] vv;
        vv = v;
        m[(r*4+c)*8 +: 8] = vv[7:0];
        return m;
    endfunction

    // Loads exp_c into the scoreboard and drains it against the whole C output.
    task automatic check_c(input string tag);
        logic [15:0] e;
        foreach (exp_c[i]) exp_q.push_back(exp_c[i][15:0]);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s c[%0d][%0d]", tag, i/4, i%4), 32'(c_matrix_o[i*16 +: 16]), 32'(e));
        end
    endtask

    // Start is high in cycle 0; lat is the cycle index (1 = cycle after start) where done_o is seen.
    task automatic do_op(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m, input logic md,
                         input logic [127:0] a, input logic [127:0] b, input logic [127:0] a_late,
                         input int hold, output int lat_o, output int pulses_o, output logic busy_o1);
        @(negedge clk_i);
        n_dim_i = n; k_dim_i = k; m_dim_i = m; mode_i = md;
        a_matrix_i = a; b_matrix_i = b; start_i = 1'b1;
        lat_o = -1; pulses_o = 0; busy_o1 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (i == hold) start_i = 1'b0;
            if (i == 2) a_matrix_i = a_late;
            if (i == 1) busy_o1 = busy_o;
            if (done_o) begin
                pulses_o++;
                if (lat_o < 0) lat_o = i;
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0;
        n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
        a_matrix_i = '0; b_matrix_i = '0;

        a_id  = put(put(128'd0, 0, 0, 1), 1, 1, 1);
        b_2x2 = put(put(put(put(128'd0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4);
        a_ones = {16{8'h7F}};
        a_nk = put(put(put(put(put(put(128'd0, 0, 0, -1), 0, 1, 2), 0, 2, 3), 1, 0, 4), 1, 1, -5), 1, 2, 6);
        b_km = put(put(put(128'd0, 0, 0, 7), 1, 0, -8), 2, 0, 9);
        a_nines = {16{8'h09}};

        repeat (3) @(negedge clk_i);
        check("rst c", 32'(|c_matrix_o), 32'd0);
        check("rst flags", 32'(flags_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst error", 32'(error_o), 32'd0);
        rst_ni = 1'b1;

        // 2x2 identity times B
        do_op(3'd2, 3'd2, 3'd2, 1'b0, a_id, b_2x2, a_id, 1, lat, pulses, busy1);
        check("id latency", 32'(lat), 32'd6);
        check("id pulses", 32'(pulses), 32'd1);
        check("id busy", 32'(busy1), 32'd1);
        exp_c = '{1,2,0,0, 3,4,0,0, 0,0,0,0, 0,0,0,0};
        check_c("id");
        check("id flags", 32'(flags_o), 32'd0);
        check("id error", 32'(error_o), 32'd0);
        check("id idle", 32'(busy_o), 32'd0);

        // Accumulate the same product on top of the held result
        do_op(3'd2, 3'd2, 3'd2, 1'b1, a_id, b_2x2, a_id, 1, lat, pulses, busy1);
        check("acc pulses", 32'(pulses), 32'd1);
        exp_c = '{2,4,0,0, 6,8,0,0, 0,0,0,0, 0,0,0,0};
        check_c("acc");

        // 4x4 of 127s: 4*16129 overflows the 16-bit accumulator on the third add
        do_op(3'd4, 3'd4, 3'd4, 1'b0, a_ones, a_ones, a_ones, 1, lat, pulses, busy1);
        check("ovf latency", 32'(lat), 32'd12);
`ifdef MATMUL_SATURATE_EN
        foreach (exp_c[i]) exp_c[i] = 32767;
`else
        foreach (exp_c[i]) exp_c[i] = -1020;
`endif
        check_c("ovf");
        check("ovf flags", 32'(flags_o), 32'h0000FFFF);

        // 2x3 times 3x1 with negatives; clears flags and zeroes outside the region
        do_op(3'd2, 3'd3, 3'd1, 1'b0, a_nk, b_km, a_nk, 1, lat, pulses, busy1);
        check("rect latency", 32'(lat), 32'd6);
        exp_c = '{4,0,0,0, 122,0,0,0, 0,0,0,0, 0,0,0,0};
        check_c("rect");
        check("rect flags", 32'(flags_o), 32'd0);

        // Illegal dimensions: 0 and 5
        do_op(3'd0, 3'd2, 3'd2, 1'b0, a_id, b_2x2, a_id, 1, lat, pulses, busy1);
        check("dim0 latency", 32'(lat), 32'd1);
        check("dim0 pulses", 32'(pulses), 32'd1);
        check("dim0 error", 32'(error_o), 32'd1);
        check_c("dim0");
        do_op(3'd5, 3'd2, 3'd2, 1'b0, a_id, b_2x2, a_id, 1, lat, pulses, busy1);
        check("dim5 latency", 32'(lat), 32'd1);
        check("dim5 error", 32'(error_o), 32'd1);
        check_c("dim5");
        check("dim5 flags", 32'(flags_o), 32'd0);

        // Reset on the third FEED cycle
        @(negedge clk_i);
        n_dim_i = 3'd2; k_dim_i = 3'd2; m_dim_i = 3'd2; mode_i = 1'b0;
        a_matrix_i = a_id; b_matrix_i = b_2x2; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("abort c", 32'(|c_matrix_o), 32'd0);
        check("abort flags", 32'(flags_o), 32'd0);
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        check("abort error", 32'(error_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);

        // Accumulating from the reset result gives the plain product
        do_op(3'd2, 3'd2, 3'd2, 1'b1, a_id, b_2x2, a_id, 1, lat, pulses, busy1);
        check("post rst latency", 32'(lat), 32'd6);
        exp_c = '{1,2,0,0, 3,4,0,0, 0,0,0,0, 0,0,0,0};
        check_c("post rst");

        // Start held through DRAIN while A changes mid-FEED
        do_op(3'd2, 3'd2, 3'd2, 1'b0, a_id, b_2x2, a_nines, 6, lat, pulses, busy1);
        check("hold pulses", 32'(pulses), 32'd1);
        check("hold latency", 32'(lat), 32'd6);
        check_c("hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/matmul_systolic_engine.md
MATMUL_SYSTOLIC_ENGINE -- requirements
Module: matmul_systolic_engine

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the signed element width of A and B.
REQ-002 The module SHALL have parameter BUS_WIDTH, default 32, where MAX_DIM = BUS_WIDTH/DATA_WIDTH is the maximum matrix dimension.
REQ-003 The module SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH, giving the signed width of each C element and each accumulator.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with the following ports:
 clk_i  in  1  clock, rising edge.
 rst_ni  in  1  asynchronous active-low reset.
 start_i  in  1  request to begin an operation; sampled only in IDLE.
 mode_i  in  1  0: C = A*B; 1: C = C_prev + A*B (accumulate).
 n_dim_i, k_dim_i, m_dim_i  in  3 each  A is N x K, B is K x M.
 a_matrix_i, b_matrix_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH  row-major, row stride MAX_DIM*DATA_WIDTH.
 c_matrix_o  out  MAX_DIM*MAX_DIM*ACC_WIDTH  row-major result.
 flags_o  out  MAX_DIM*MAX_DIM  per-element overflow, bit index row*MAX_DIM+col.
 busy_o  out  1  high while an operation is in progress.
 done_o  out  1  one-cycle completion pulse.
 error_o  out  1  last request had illegal dimensions.

Function
REQ-005 The module SHALL implement an FSM with states IDLE, FEED, DRAIN and DONE.
REQ-006 In IDLE, start_i=1 SHALL snapshot all inputs (dims, mode, A, B) into internal registers, and later input changes SHALL have no effect.
REQ-007 A request with any dimension equal to 0 or greater than MAX_DIM SHALL go IDLE->DONE, set error_o, and leave c_matrix_o and flags_o unchanged.
REQ-008 A legal request SHALL clear error_o, enter FEED, and (when mode=0) zero all accumulators and flags.
REQ-009 FEED SHALL last N+K+M-2 cycles; on feed cycle t, row r SHALL receive A[r][t-r] and column c SHALL receive B[t-c][c], and zero wherever the index is out of range.
REQ-010 The array SHALL be MAX_DIM x MAX_DIM PEs, each with a one-cycle register on its A-out and B-out paths and a MAC accumulator.
REQ-011 DRAIN SHALL last exactly 1 cycle, after which the FSM SHALL enter DONE.
REQ-012 In DONE, done_o SHALL be 1 for exactly one cycle and c_matrix_o SHALL be updated, after which the FSM SHALL return to IDLE.
REQ-013 busy_o SHALL be 1 in FEED, DRAIN and DONE, and 0 in IDLE.
REQ-014 c_matrix_o SHALL hold its value between operations, and elements outside the N x M region SHALL be zero.
REQ-015 start_i while busy_o=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 In accumulate mode, each accumulator SHALL start from its element of the held c_matrix_o, and flags_o SHALL be sticky (OR with the previous value).
REQ-017 Each product SHALL be a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH before being added.
REQ-018 A flag bit SHALL set when a signed add in that PE overflows ACC_WIDTH.

Reset
REQ-019 On rst_ni=0, asynchronously: FSM=IDLE, and c_matrix_o, flags_o, busy_o, done_o, error_o, all PE registers and all snapshots SHALL be 0.
REQ-020 A reset during FEED or DRAIN SHALL abort the operation with no done_o pulse.

Configuration
REQ-021 With macro MATMUL_SATURATE_EN defined, an overflowing add SHALL clamp to +(2^(ACC_WIDTH-1))-1 or -(2^(ACC_WIDTH-1)) and hold that value for the rest of the operation.
REQ-022 Without MATMUL_SATURATE_EN, an overflowing add SHALL wrap modulo 2^ACC_WIDTH; flags_o SHALL set identically in both builds.

Verification (DATA_WIDTH=8, BUS_WIDTH=32, MAX_DIM=4)
REQ-023 Scenario: N=K=M=2, A=identity, B=[[1,2],[3,4]], mode=0 -> done_o 5 cycles after start is accepted, C=[[1,2],[3,4]], other elements 0, flags=0.
REQ-024 Scenario: repeat REQ-023 immediately with mode=1 -> C=[[2,4],[6,8]].
REQ-025 Scenario: N=K=M=4, all A and B elements 127 -> with MATMUL_SATURATE_EN every C=32767; without it every C=-1020; flags_o=16'hFFFF in both builds.
REQ-026 Scenario: n_dim_i=0 or n_dim_i=5 -> error_o=1, done_o one cycle after start, C unchanged.
REQ-027 Scenario: rst_ni pulsed low on the third FEED cycle -> all outputs 0 at once and no done_o pulse; a following legal start computes correctly.
REQ-028 Scenario: start_i held high and A changed during FEED -> exactly one done_o pulse, and the result uses the A captured at start.
